mem_trace_monitor: RTL and testbench

//  Parametrised run-control and memory-write tracer for the computer core: filters RAM write-bus

---
 rtl/mem_trace_pkg.sv | 18 +
 rtl/mem_trace_monitor_fifo.sv | 49 ++++
 rtl/mem_trace_monitor.sv | 114 +++++++++++
 tb/tb_mem_trace_monitor.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_trace_pkg.sv
// Shared types, default widths and the address-window helper for the memory write tracer.
package mem_trace_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int DEF_STAMP_W = 16;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 16;
  localparam int REC_W       = DEF_STAMP_W + DEF_ADDR_W + DEF_DATA_W;

  // Wide operands so base+size never wraps, whatever the address width.
  function automatic logic in_window(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] size);
    return (addr >= base) && (addr < base + size);
  endfunction

endpackage

// File: rtl/mem_trace_monitor_fifo.sv
// Synchronous trace FIFO: register storage, extra pointer bit to tell full from empty.
module trace_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees a slot in the same cycle, so a full FIFO may still accept a push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/mem_trace_monitor.sv
// Run control plus windowed RAM-write capture into a drainable trace FIFO.
module mem_trace_monitor
  import mem_trace_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int STAMP_W     = DEF_STAMP_W,
  parameter int DEPTH       = 16,
  parameter int WIN_BASE    = 0,
  parameter int WIN_SIZE    = 9,
  parameter int CYC_W       = 32,
  parameter int CYCLE_LIMIT = 1000
) (
  input  logic                              clock_50_b7a,
  input  logic                              reset,
  input  logic                              arm,
  input  logic                              stop,
  input  logic                              mem_we,
  input  logic [ADDR_W-1:0]                 mem_addr,
  input  logic [DATA_W-1:0]                 mem_wdata,
  output logic                              t_valid,
  input  logic                              t_ready,
  output logic [STAMP_W+ADDR_W+DATA_W-1:0]  t_data,
  output logic [CYC_W-1:0]                  cycles,
  output logic                              overflow,
  output logic [7:0]                        drop_cnt,
  output logic                              running,
  output logic                              done
);

  localparam int                REC_BITS   = STAMP_W + ADDR_W + DATA_W;
  localparam logic [CYC_W-1:0] LIMIT_LAST = CYC_W'(CYCLE_LIMIT - 1);

  state_e                state_q, state_d;
  logic [CYC_W-1:0]      cycles_q, cycles_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;
  logic                  clear_stats;
  logic                  capture, pop, drop, full, empty;
  logic [REC_BITS-1:0]   rec;

  assign capture = (state_q == RUN) && mem_we &&
                   in_window(64'(mem_addr), 64'(WIN_BASE), 64'(WIN_SIZE));
  assign rec     = {cycles_q[STAMP_W-1:0], mem_addr, mem_wdata};
  assign pop     = t_ready && !empty;
  assign drop    = capture && full && !pop;

  always_comb begin
    state_d     = state_q;
    cycles_d    = cycles_q;
    clear_stats = 1'b0;
    case (state_q)
      IDLE: if (arm) state_d = RUN;
      RUN: begin
        cycles_d = cycles_q + CYC_W'(1);
        if (stop || ((CYCLE_LIMIT != 0) && (cycles_q == LIMIT_LAST))) state_d = DONE;
      end
      DONE: if (arm) begin
        state_d     = RUN;
        cycles_d    = '0;
        clear_stats = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clear_stats) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock_50_b7a or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cycles_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cycles_q   <= cycles_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  trace_fifo #(
    .WIDTH (REC_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clock_50_b7a),
    .rst     (reset),
    .push_i  (capture),
    .pop_i   (pop),
    .wdata_i (rec),
    .rdata_o (t_data),
    .full_o  (full),
    .empty_o (empty)
  );

  assign t_valid  = !empty;
  assign cycles   = cycles_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
  assign running  = (state_q == RUN);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_mem_trace_monitor.sv
// Directed bench for mem_trace_monitor with a queue-based reference model checked every cycle.
module tb_mem_trace_monitor;
  import mem_trace_pkg::*;

  localparam int DEPTH    = 16;
  localparam int LIMIT    = 1000;
  localparam int WIN_BASE = 0;
  localparam int WIN_SIZE = 9;

  logic              clk      = 1'b0;
  logic              reset    = 1'b0;
  logic              arm      = 1'b0;
  logic              stop     = 1'b0;
  logic              memWe    = 1'b0;
  logic [15:0]       memAddr  = '0;
  logic [15:0]       memWdata = '0;
  logic              tReady   = 1'b0;
  logic              tValid;
  logic [REC_W-1:0]  tData;
  logic [31:0]       cycles;
  logic              overflow;
  logic [7:0]        dropCnt;
  logic              running;
  logic              done;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 1'b0;

  // Reference model: the trace is just a bounded queue of records in arrival order.
  logic [REC_W-1:0] modelQ[$];
  int               phase     = 0;
  int               mCycles   = 0;
  bit               mOverflow = 1'b0;
  int               mDrops    = 0;

  bit          sReset, sArm, sStop, sWe, sReady;
  logic [15:0] sAddr, sData;

  always #5 clk = ~clk;

  mem_trace_monitor dut (
    .clock_50_b7a (clk),
    .reset        (reset),
    .arm          (arm),
    .stop         (stop),
    .mem_we       (memWe),
    .mem_addr     (memAddr),
    .mem_wdata    (memWdata),
    .t_valid      (tValid),
    .t_ready      (tReady),
    .t_data       (tData),
    .cycles       (cycles),
    .overflow     (overflow),
    .drop_cnt     (dropCnt),
    .running      (running),
    .done         (done)
  );

  task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    modelQ.delete();
    phase     = 0;
    mCycles   = 0;
    mOverflow = 1'b0;
    mDrops    = 0;
  endtask

  task automatic stepModel();
    bit               popped, capt;
    logic [REC_W-1:0] rec;
    popped = sReady && (modelQ.size() > 0);
    capt   = (phase == 1) && sWe && (int'(sAddr) >= WIN_BASE) && (int'(sAddr) < WIN_BASE + WIN_SIZE);
    rec    = {16'(mCycles), sAddr, sData};
    if (popped) void'(modelQ.pop_front());
    if (capt) begin
      if (modelQ.size() < DEPTH) modelQ.push_back(rec);
      else begin
        mOverflow = 1'b1;
        if (mDrops < 255) mDrops++;
      end
    end
    case (phase)
      0: if (sArm) phase = 1;
      1: begin
        mCycles++;
        if (sStop || mCycles == LIMIT) phase = 2;
      end
      2: if (sArm) begin
        phase     = 1;
        mCycles   = 0;
        mOverflow = 1'b0;
        mDrops    = 0;
      end
      default: phase = 0;
    endcase
  endtask

  task automatic checkOutput();
    checkField("model_t_valid", 64'(tValid), 64'(modelQ.size() > 0));
    checkField("model_t_data", 64'(tData), (modelQ.size() > 0) ? 64'(modelQ[0]) : 64'd0);
    checkField("model_cycles", 64'(cycles), 64'(mCycles));
    checkField("model_overflow", 64'(overflow), 64'(mOverflow));
    checkField("model_drop_cnt", 64'(dropCnt), 64'(mDrops));
    checkField("model_running", 64'(running), 64'(phase == 1));
    checkField("model_done", 64'(done), 64'(phase == 2));
  endtask

  task automatic applyStimulus(input bit a, input bit s, input bit we,
                               input logic [15:0] addr, input logic [15:0] data, input bit rdy);
    arm      = a;
    stop     = s;
    memWe    = we;
    memAddr  = addr;
    memWdata = data;
    tReady   = rdy;
    @(negedge clk);
    #1;
  endtask

  // Inputs are sampled at the active edge; the model advances and is compared half a cycle later.
  initial forever begin
    @(posedge clk);
    sReset = reset;
    sArm   = arm;
    sStop  = stop;
    sWe    = memWe;
    sAddr  = memAddr;
    sData  = memWdata;
    sReady = tReady;
  end

  initial forever begin
    @(negedge clk);
    if (reset || sReset) resetModel();
    else stepModel();
    if (checkEn) checkOutput();
  end

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    checkEn = 1'b1;

    applyStimulus(0, 0, 0, 16'd0, 16'h0000, 0);
    checkField("reset_cycles", 64'(cycles), 64'd0);
    checkField("reset_running", 64'(running), 64'd0);
    checkField("reset_t_data", 64'(tData), 64'd0);

    repeat (3) applyStimulus(0, 0, 1, 16'd3, 16'h1111, 0);
    checkField("idle_write_ignored", 64'(tValid), 64'd0);

    applyStimulus(1, 0, 0, 16'd0, 16'h0000, 0);
    checkField("arm_running", 64'(running), 64'd1);
    repeat (5) applyStimulus(0, 0, 0, 16'd0, 16'h0000, 0);
    applyStimulus(0, 0, 1, 16'd2, 16'hBEEF, 0);
    checkField("capture_valid", 64'(tValid), 64'd1);
    checkField("capture_record", 64'(tData), 64'({16'd5, 16'd2, 16'hBEEF}));
    applyStimulus(0, 0, 1, 16'd9, 16'h1234, 0);
    checkField("outside_window_head", 64'(tData), 64'({16'd5, 16'd2, 16'hBEEF}));
    applyStimulus(0, 0, 0, 16'd0, 16'h0000, 1);
    checkField("single_record_drained", 64'(tValid), 64'd0);

    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1, 16'(i % 9), 16'(16'h0100 + i), 0);
    checkField("bp_overflow", 64'(overflow), 64'd1);
    checkField("bp_drop_cnt", 64'(dropCnt), 64'd4);
    checkField("bp_head", 64'(tData[31:0]), 64'({16'd0, 16'h0100}));
    for (int i = 0; i < 16; i++) begin
      checkField("bp_drain_order", 64'(tData[15:0]), 64'(16'h0100 + i));
      applyStimulus(0, 0, 0, 16'd0, 16'h0000, 1);
    end
    checkField("bp_drained_empty", 64'(tValid), 64'd0);

    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, 16'(i % 9), 16'(16'h0200 + i), 0);
    applyStimulus(0, 0, 1, 16'd7, 16'h02FF, 1);
    checkField("full_pushpop_no_drop", 64'(dropCnt), 64'd4);
    checkField("full_pushpop_head", 64'(tData[15:0]), 64'h0201);
    for (int i = 0; i < 16; i++) begin
      checkField("full_drain_order", 64'(tData[15:0]), (i < 15) ? 64'(16'h0201 + i) : 64'h02FF);
      applyStimulus(0, 0, 0, 16'd0, 16'h0000, 1);
    end
    checkField("full_drained_empty", 64'(tValid), 64'd0);

    for (int i = 0; i < 1200 && phase != 2; i++) begin
      if (mCycles == LIMIT - 1) applyStimulus(0, 0, 1, 16'd4, 16'hD999, 0);
      else applyStimulus(0, 0, 0, 16'd0, 16'h0000, 0);
    end
    if (phase != 2) begin
      checks++;
      failures++;
      $display("[TB] FAIL limit_timeout actual=phase%0d required=phase2", phase);
    end
    checkField("limit_done", 64'(done), 64'd1);
    checkField("limit_cycles", 64'(cycles), 64'd1000);
    checkField("limit_last_capture", 64'(tData), 64'({16'd999, 16'd4, 16'hD999}));
    applyStimulus(0, 0, 1, 16'd5, 16'h5555, 0);
    checkField("done_cycles_hold", 64'(cycles), 64'd1000);

    applyStimulus(1, 0, 0, 16'd0, 16'h0000, 0);
    checkField("rearm_cycles", 64'(cycles), 64'd0);
    checkField("rearm_overflow", 64'(overflow), 64'd0);
    checkField("rearm_drop_cnt", 64'(dropCnt), 64'd0);
    checkField("rearm_kept_record", 64'(tData), 64'({16'd999, 16'd4, 16'hD999}));
    applyStimulus(0, 0, 0, 16'd0, 16'h0000, 1);
    checkField("done_write_not_captured", 64'(tValid), 64'd0);

    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 16'(i), 16'(16'h0300 + i), 0);
    checkField("pre_reset_valid", 64'(tValid), 64'd1);
    #2 reset = 1'b1;
    #1;
    checkField("async_reset_valid", 64'(tValid), 64'd0);
    checkField("async_reset_t_data", 64'(tData), 64'd0);
    checkField("async_reset_running", 64'(running), 64'd0);
    @(negedge clk);
    #2 reset = 1'b0;

    applyStimulus(1, 0, 0, 16'd0, 16'h0000, 0);
    repeat (3) applyStimulus(0, 0, 0, 16'd0, 16'h0000, 0);
    applyStimulus(0, 1, 0, 16'd0, 16'h0000, 0);
    checkField("stop_done", 64'(done), 64'd1);
    checkField("stop_cycles", 64'(cycles), 64'd4);
    applyStimulus(0, 0, 0, 16'd0, 16'h0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
